// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants for the fetch stage and the pipeline registers built around it.
package pc_fetch_stage_pkg;
    localparam int          WL           = 32;
    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_INCR      = 32'd4;
    localparam int          JUMP_FIELD_W = 26;
endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// Generic pipeline register with hold (en=0) and clear-to-zero; clear wins over hold.
module if_id_reg #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr)     q_d = '0;
        else if (en) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter, next-PC redirect mux and IF/ID register for the MIPS pipeline.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter int          WL       = pc_fetch_stage_pkg::WL,
    parameter logic [31:0] RESET_PC = pc_fetch_stage_pkg::RESET_PC
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    StallF,
    input  logic                    StallD,
    input  logic                    FlushD,
    input  logic                    PCSrcD,
    input  logic [WL:0]             BranchTarget,
    input  logic                    JumpD,
    input  logic [JUMP_FIELD_W-1:0] JumpIndexD,
    input  logic [WL-1:0]           InstrF,
    output logic [WL-1:0]           PCF,
    output logic [WL-1:0]           PCPlus4F,
    output logic [WL-1:0]           InstrD,
    output logic [WL-1:0]           PCPlus4D,
    output logic                    ValidD,
    output logic                    MisalignD
);
    logic [WL-1:0] pc_q, pc_d;
    logic          misalign_q, misalign_d;
    logic          unused_bt_carry;

    // Adder carry-out is meaningless for a wrapping address space.
    assign unused_bt_carry = BranchTarget[WL];

    assign PCPlus4F = pc_q + PC_INCR;

    always_comb begin
        pc_d       = PCPlus4F;
        misalign_d = 1'b0;
        if (StallF) begin
            pc_d = pc_q;
        end else if (JumpD) begin
            pc_d = {PCPlus4D[WL-1:WL-4], JumpIndexD, 2'b00};
        end else if (PCSrcD) begin
            pc_d       = {BranchTarget[WL-1:2], 2'b00};
            misalign_d = |BranchTarget[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign PCF       = pc_q;
    assign MisalignD = misalign_q;

    // Clear value is all-zero, which is also NOP_INSTR with ValidD=0.
    if_id_reg #(.W(2*WL+1)) u_if_id (
        .clk (CLK),
        .rst (RST),
        .en  (~StallD),
        .clr (FlushD),
        .d   ({1'b1, PCPlus4F, InstrF}),
        .q   ({ValidD, PCPlus4D, InstrD})
    );
endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: a behavioural model predicts each cycle's outputs.
module tb_pc_fetch_stage;
    localparam logic [31:0] K = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc, pcp4f, instr, pcp4;
        logic        valid, mis;
    } snap_t;

    logic        CLK = 1'b0;
    logic        RST, StallF, StallD, FlushD, PCSrcD, JumpD;
    logic [32:0] BranchTarget;
    logic [25:0] JumpIndexD;
    logic [31:0] InstrF, PCF, PCPlus4F, InstrD, PCPlus4D;
    logic        ValidD, MisalignD;

    int checks = 0;
    int errors = 0;
    snap_t sb[$];
    snap_t m = '0;
    snap_t e, o;

    always #5 CLK = ~CLK;
    assign InstrF = PCF ^ K;

    pc_fetch_stage dut (
        .CLK(CLK), .RST(RST), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcD(PCSrcD), .BranchTarget(BranchTarget), .JumpD(JumpD),
        .JumpIndexD(JumpIndexD), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignD(MisalignD)
    );

    function automatic snap_t obs();
        return '{PCF, PCPlus4F, InstrD, PCPlus4D, ValidD, MisalignD};
    endfunction

    // Called at a falling edge: apply inputs, predict, push, cross one rising edge.
    task automatic drive(input logic rst, sf, sd, fd, pcs, input logic [32:0] bt,
                         input logic j, input logic [25:0] ji);
        snap_t n;
        logic [31:0] p4;
        RST = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcD = pcs;
        BranchTarget = bt; JumpD = j; JumpIndexD = ji;
        n  = m;
        p4 = m.pc + 32'd4;
        if (rst) begin
            n = '0;
        end else begin
            n.mis = 1'b0;
            if (!sf) begin
                if (j)        n.pc = {m.pcp4[31:28], ji, 2'b00};
                else if (pcs) begin
                    n.pc  = {bt[31:2], 2'b00};
                    n.mis = (bt[1:0] != 2'b00);
                end else      n.pc = p4;
            end
            if (fd) begin
                n.instr = 32'h0; n.pcp4 = 32'h0; n.valid = 1'b0;
            end else if (!sd) begin
                n.instr = m.pc ^ K; n.pcp4 = p4; n.valid = 1'b1;
            end
        end
        n.pcp4f = n.pc + 32'd4;
        m = n;
        sb.push_back(n);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 33'h0, 0, 26'h0);
    endtask

    task automatic redirect(input logic [32:0] bt);
        drive(0, 0, 0, 1, 1, bt, 0, 26'h0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 1, 33'h44, 1, 26'h3);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL reset: got %h exp %h", o, e); end
        end
        checks++;
        if ({PCF, InstrD, PCPlus4D, ValidD, MisalignD} !== 98'h0) begin
            errors++; $display("FAIL reset_zero: got pc=%h v=%b", PCF, ValidD);
        end
    endtask

    task automatic test_free_run();
        for (int i = 1; i <= 4; i++) begin
            idle();
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e) begin errors++; $display("FAIL free_run: got %h exp %h", o, e); end
            checks++;
            if (PCF !== 32'(4 * i) || ValidD !== 1'b1 || PCPlus4D !== 32'(4 * i)) begin
                errors++; $display("FAIL free_run_pc: got pc=%h v=%b p4d=%h exp pc=%h", PCF, ValidD, PCPlus4D, 4 * i);
            end
        end
    endtask

    task automatic test_branch();
        redirect(33'h30);
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL branch: got %h exp %h", o, e); end
        checks++;
        if (PCF !== 32'h30 || ValidD !== 1'b0 || MisalignD !== 1'b0) begin
            errors++; $display("FAIL branch_pc: got pc=%h v=%b mis=%b exp pc=30 v=0 mis=0", PCF, ValidD, MisalignD);
        end
    endtask

    task automatic test_jump_misalign();
        redirect(33'h0040_000C);
        idle();
        void'(sb.pop_front());
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCPlus4D !== 32'h0040_0010) begin
            errors++; $display("FAIL jump_setup: got %h exp %h", o, e);
        end
        drive(0, 0, 0, 1, 1, 33'h80, 1, 26'h40);
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCF !== 32'h100) begin
            errors++; $display("FAIL jump_prio: got %h exp %h", o, e);
        end
        redirect(33'h1_0000_0006);
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCF !== 32'h4 || MisalignD !== 1'b1) begin
            errors++; $display("FAIL misalign: got pc=%h mis=%b exp pc=4 mis=1", PCF, MisalignD);
        end
        idle();
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || MisalignD !== 1'b0) begin
            errors++; $display("FAIL misalign_pulse: got mis=%b exp 0", MisalignD);
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc0, in0;
        pc0 = PCF; in0 = InstrD;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, (i == 1), 33'h500, 0, 26'h0);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e || PCF !== pc0 || InstrD !== in0 || ValidD !== 1'b1) begin
                errors++; $display("FAIL stall: got pc=%h instr=%h exp pc=%h instr=%h", PCF, InstrD, pc0, in0);
            end
        end
        idle();
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCF !== pc0 + 32'd4) begin
            errors++; $display("FAIL stall_release: got pc=%h exp %h", PCF, pc0 + 32'd4);
        end
    endtask

    task automatic test_stallf_only();
        logic [31:0] pc0;
        pc0 = PCF;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 0, 0, 33'h0, 0, 26'h0);
            e = sb.pop_front(); o = obs(); checks++;
            if (o !== e || InstrD !== (pc0 ^ K) || ValidD !== 1'b1) begin
                errors++; $display("FAIL stallf_dup: got instr=%h v=%b exp instr=%h", InstrD, ValidD, pc0 ^ K);
            end
        end
    endtask

    task automatic test_flush_vs_stall();
        drive(0, 0, 1, 1, 0, 33'h0, 0, 26'h0);
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || InstrD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
            errors++; $display("FAIL flush_vs_stall: got instr=%h p4d=%h v=%b exp 0", InstrD, PCPlus4D, ValidD);
        end
    endtask

    task automatic test_reset_mid();
        redirect(33'h200);
        idle();
        void'(sb.pop_front());
        void'(sb.pop_front());
        drive(1, 1, 1, 0, 1, 33'h300, 1, 26'h5);
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCF !== 32'h0 || {InstrD, PCPlus4D, ValidD, MisalignD} !== 66'h0) begin
            errors++; $display("FAIL reset_mid: got %h exp %h", o, e);
        end
    endtask

    task automatic test_wrap();
        redirect(33'h0_FFFF_FFFC);
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0) begin
            errors++; $display("FAIL wrap_p4f: got pc=%h p4f=%h exp pc=fffffffc p4f=0", PCF, PCPlus4F);
        end
        idle();
        e = sb.pop_front(); o = obs(); checks++;
        if (o !== e || PCF !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got pc=%h exp 0", PCF);
        end
    endtask

    initial begin
        RST = 1; StallF = 0; StallD = 0; FlushD = 0; PCSrcD = 0; JumpD = 0;
        BranchTarget = '0; JumpIndexD = '0;
        @(negedge CLK);
        test_reset();
        test_free_run();
        test_branch();
        test_jump_misalign();
        test_stall();
        test_stallf_only();
        test_flush_vs_stall();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
